ponylink_stream_exerciser: RTL

//  Parametrised traffic generator plus checker for the PonyLink AXI-stream ports. Generator drives
//  in_t* of a ponylink_master/slave with framed, sequence-coded packets. Checker consumes out_t* of
//  the far end and flags data, tuser and framing errors. Intended for bring-up and BMC harnesses.

---
 rtl/ponylink_stream_exerciser.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ponylink_stream_exerciser.sv
// Purpose: PonyLink AXI-stream exerciser; framed sequence-coded traffic out on in_t*, checks out_t*, sticky error flags.
// Latency: in_tvalid rises one cycle after enable && linkready; checker counters/flags update one cycle after an accepted beat.
// Backpressure: generator holds each beat stable until in_tready; checker accepts only while out_tready (READY_PATTERN) is high.
module ponylink_stream_exerciser #(
    parameter int          TDATA_WIDTH   = 8,
    parameter int          TUSER_WIDTH   = 4,
    parameter int          PKT_LEN       = 8,
    parameter int          PATTERN       = 0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic [15:0] READY_PATTERN = 16'hFFFF,
    parameter int          CNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic                   linkready,
    output logic [TDATA_WIDTH-1:0] in_tdata,
    output logic [TUSER_WIDTH-1:0] in_tuser,
    output logic                   in_tvalid,
    output logic                   in_tlast,
    input  logic                   in_tready,
    input  logic [TDATA_WIDTH-1:0] out_tdata,
    input  logic [TUSER_WIDTH-1:0] out_tuser,
    input  logic                   out_tvalid,
    input  logic                   out_tlast,
    output logic                   out_tready,
    output logic [CNT_WIDTH-1:0]   tx_pkt_count,
    output logic [CNT_WIDTH-1:0]   rx_pkt_count,
    output logic                   err_data,
    output logic                   err_length
);

    // Sequence state is at least 16 bits so the LFSR fits; the counter
    // pattern only exposes its low TDATA_WIDTH bits, which wrap correctly.
    localparam int SEQ_W  = (TDATA_WIDTH > 16) ? TDATA_WIDTH : 16;
    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
    localparam logic [SEQ_W-1:0]  SEQ_INIT  = (PATTERN == 1) ? SEQ_W'(LFSR_SEED) : '0;

    typedef enum logic [0:0] {
        GEN_IDLE = 1'b0,
        GEN_SEND = 1'b1
    } gen_state_e;

    // One step of the data sequence: +1 counter, or one shift of the
    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 (taps at bits 0,2,3,5 when
    // shifting right).
    function automatic logic [SEQ_W-1:0] seq_step(input logic [SEQ_W-1:0] s);
        logic [SEQ_W-1:0] r;
        if (PATTERN == 1) begin
            r       = '0;
            r[15:0] = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        end else begin
            r = s + SEQ_W'(1);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Generator
    // ------------------------------------------------------------------
    gen_state_e          state_q, state_d;
    logic [SEQ_W-1:0]    tx_seq_q, tx_seq_d;
    logic [BEAT_W-1:0]   tx_beat_q, tx_beat_d;
    logic [CNT_WIDTH-1:0] tx_pkt_cnt_q, tx_pkt_cnt_d;
    logic                tx_vld;
    logic                tx_last;
    logic                tx_fire;

    assign tx_last = (tx_beat_q == LAST_BEAT);
    assign tx_fire = tx_vld && in_tready;

    // Generator state register; reset abandons any partial packet.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= GEN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start needs enable and link; once sending, only a completed packet
    // with enable low returns to idle, so packets are never truncated.
    always_comb begin
        state_d = state_q;
        case (state_q)
            GEN_IDLE: begin
                if (enable && linkready) begin
                    state_d = GEN_SEND;
                end
            end
            GEN_SEND: begin
                if (tx_fire && tx_last && !enable) begin
                    state_d = GEN_IDLE;
                end
            end
            default: state_d = GEN_IDLE;
        endcase
    end

    // Valid is a direct decode of the state flop, so it is registered.
    always_comb begin
        tx_vld = (state_q == GEN_SEND);
    end

    // Beat position, sequence and packet count advance only on accepted beats.
    always_comb begin
        tx_seq_d     = tx_seq_q;
        tx_beat_d    = tx_beat_q;
        tx_pkt_cnt_d = tx_pkt_cnt_q;
        if (tx_fire) begin
            tx_seq_d = seq_step(tx_seq_q);
            if (tx_last) begin
                tx_beat_d    = '0;
                tx_pkt_cnt_d = tx_pkt_cnt_q + CNT_WIDTH'(1);
            end else begin
                tx_beat_d = tx_beat_q + BEAT_W'(1);
            end
        end
    end

    // Generator datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_seq_q     <= SEQ_INIT;
            tx_beat_q    <= '0;
            tx_pkt_cnt_q <= '0;
        end else begin
            tx_seq_q     <= tx_seq_d;
            tx_beat_q    <= tx_beat_d;
            tx_pkt_cnt_q <= tx_pkt_cnt_d;
        end
    end

    // Payload is zeroed while idle so every output reads 0 out of reset,
    // even when the LFSR seed is nonzero.
    always_comb begin
        in_tvalid = tx_vld;
        in_tdata  = tx_vld ? tx_seq_q[TDATA_WIDTH-1:0] : '0;
        in_tuser  = tx_vld ? tx_pkt_cnt_q[TUSER_WIDTH-1:0] : '0;
        in_tlast  = tx_vld && tx_last;
    end

    assign tx_pkt_count = tx_pkt_cnt_q;

    // ------------------------------------------------------------------
    // Checker ready pattern
    // ------------------------------------------------------------------
    logic [3:0] rdy_idx_q;
    logic       out_tready_q;

    // Ready walks READY_PATTERN one bit per cycle; first bit appears one
    // cycle after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_idx_q    <= '0;
            out_tready_q <= 1'b0;
        end else begin
            rdy_idx_q    <= rdy_idx_q + 4'd1;
            out_tready_q <= READY_PATTERN[rdy_idx_q];
        end
    end

    assign out_tready = out_tready_q;

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    logic [SEQ_W-1:0]     rx_seq_q, rx_seq_d;
    logic [BEAT_W-1:0]    rx_beat_q, rx_beat_d;
    logic [CNT_WIDTH-1:0] rx_pkt_cnt_q, rx_pkt_cnt_d;
    logic                 err_data_q, err_data_d;
    logic                 err_length_q, err_length_d;
    logic                 rx_fire;
    logic                 rx_last_exp;
    logic                 rx_data_bad;

    assign rx_fire     = out_tvalid && out_tready_q;
    assign rx_last_exp = (rx_beat_q == LAST_BEAT);
    assign rx_data_bad = (out_tdata != rx_seq_q[TDATA_WIDTH-1:0]) ||
                         (out_tuser != rx_pkt_cnt_q[TUSER_WIDTH-1:0]);

    // Compare each accepted beat; tlast always resyncs framing, while a
    // missing tlast only wraps the beat position without counting a packet.
    always_comb begin
        rx_seq_d     = rx_seq_q;
        rx_beat_d    = rx_beat_q;
        rx_pkt_cnt_d = rx_pkt_cnt_q;
        err_data_d   = err_data_q;
        err_length_d = err_length_q;
        if (rx_fire) begin
            rx_seq_d = seq_step(rx_seq_q);
            if (rx_data_bad) begin
                err_data_d = 1'b1;
            end
            if (out_tlast != rx_last_exp) begin
                err_length_d = 1'b1;
            end
            if (out_tlast) begin
                rx_beat_d    = '0;
                rx_pkt_cnt_d = rx_pkt_cnt_q + CNT_WIDTH'(1);
            end else if (rx_last_exp) begin
                rx_beat_d = '0;
            end else begin
                rx_beat_d = rx_beat_q + BEAT_W'(1);
            end
        end
    end

    // Checker registers; error flags are sticky until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_seq_q     <= SEQ_INIT;
            rx_beat_q    <= '0;
            rx_pkt_cnt_q <= '0;
            err_data_q   <= 1'b0;
            err_length_q <= 1'b0;
        end else begin
            rx_seq_q     <= rx_seq_d;
            rx_beat_q    <= rx_beat_d;
            rx_pkt_cnt_q <= rx_pkt_cnt_d;
            err_data_q   <= err_data_d;
            err_length_q <= err_length_d;
        end
    end

    assign rx_pkt_count = rx_pkt_cnt_q;
    assign err_data     = err_data_q;
    assign err_length   = err_length_q;

endmodule
